// File: rtl/reset_sequencer_if.sv
// Request inputs and staged reset outputs of the fabric reset sequencer.
// The master drives the requests and the slave drives the staged resets.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  ext_rst_req;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic [1:0]            state;
  logic [7:0]            rst_count;

  modport master (
    output ext_rst_req, sw_rst_req,
    input  stage_rst_n, seq_done, state, rst_count
  );

  modport slave (
    input  ext_rst_req, sw_rst_req,
    output stage_rst_n, seq_done, state, rst_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Fabric reset sequencer: holds every domain in reset, then releases the
// active-low stage resets one by one, restarting on ext/sw reset requests.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               SYSCLK,
  input logic               SYSRESET,
  reset_sequencer_if.slave  rs
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || SYNC_STAGES < 2 ||
      CNT_W < 1 || (HOLD_CYCLES >> CNT_W) != 0 || (STAGE_GAP >> CNT_W) != 0) begin : g_param_check
    $error("reset_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_s;
  logic                   ext_s_d;
  logic                   accept;
  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [NUM_STAGES-1:0]  rst_n_q, rst_n_n;
  logic                   done_q, done_n;
  logic [7:0]             count_q, count_n;

  assign ext_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    rst_n_n = rst_n_q;
    done_n  = done_q;
    count_n = count_q;
    cnt_inc = cnt_q + CNT_W'(1);
    // A sw pulse and an ext_s rising edge on the same edge count once.
    accept  = rs.sw_rst_req | (ext_s & ~ext_s_d);

    if (accept || ext_s) begin
      state_n = HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      rst_n_n = '0;
      done_n  = 1'b0;
      if (accept) count_n = sat_inc8(count_q);
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
            cnt_n      = '0;
            rst_n_n[0] = 1'b1;
            idx_n      = IDX_W'(1);
            if (NUM_STAGES == 1) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              state_n = RELEASE;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt_inc == CNT_W'(STAGE_GAP)) begin
            cnt_n          = '0;
            rst_n_n[idx_q] = 1'b1;
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
        RUN:     state_n = RUN;
        default: state_n = HOLD;
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      sync_q  <= '0;
      ext_s_d <= 1'b0;
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rs.ext_rst_req};
      ext_s_d <= ext_s;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      rst_n_q <= rst_n_n;
      done_q  <= done_n;
      count_q <= count_n;
    end
  end

  assign rs.stage_rst_n = rst_n_q;
  assign rs.seq_done    = done_q;
  assign rs.state       = state_q;
  assign rs.rst_count   = count_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised fabric reset sequencer for the capture design. It generates a minimum-length reset hold, then releases NUM_STAGES downstream reset domains one at a time, spaced by a programmable gap. It re-runs the whole sequence on an external or software reset request. Outputs are active-low so they feed MSS_RESET_N-style inputs directly, and a saturating event counter is exposed for firmware diagnostics.

Parameters:
NUM_STAGES, 4, number of staged reset outputs (>=1)
HOLD_CYCLES, 10, cycles all stages are held in reset before the first release (>=1)
STAGE_GAP, 16, cycles between consecutive stage releases (>=1)
CNT_W, 16, width of the internal cycle counter; must hold max(HOLD_CYCLES, STAGE_GAP)
SYNC_STAGES, 2, synchroniser depth for ext_rst_req (>=2)

Ports:
SYSCLK  in  1  single system clock; all logic on its rising edge
SYSRESET  in  1  synchronous, active-high reset
ext_rst_req  in  1  asynchronous level reset request from a pin or another domain
sw_rst_req  in  1  single-cycle software reset pulse, SYSCLK domain
stage_rst_n  out  NUM_STAGES  active-low staged resets; bit 0 is released first
seq_done  out  1  high once every stage is released
state  out  2  current state: 0=HOLD, 1=RELEASE, 2=RUN
rst_count  out  8  number of accepted reset requests since SYSRESET; saturates at 255

Behaviour:
- Clocking and reset: one clock, SYSCLK. Reset is synchronous and active-high on SYSRESET. While SYSRESET=1, on every edge:
  - state=HOLD, cycle counter=0, stage index=0
  - stage_rst_n=all 0, seq_done=0, rst_count=0
  - all synchroniser flops=0
- Registered outputs: all outputs are registered, with no combinational path from any input.
- ext_rst_req synchronisation: passes through SYNC_STAGES flops; call the result ext_s. A request is accepted on:
  - an ext_s rising edge, or
  - any edge that samples sw_rst_req=1
- Effect of an accepted request, in any state, on that same edge:
  - state goes to HOLD, counter clears, stage_rst_n goes to all 0, seq_done goes to 0
  - rst_count increments, saturating at 255
  - sw and ext requests on the same edge count once
- ext_s level hold: while ext_s=1, the sequencer stays in HOLD with the counter held at 0. Hold counting starts on the first edge where ext_s=0.
- HOLD:
  - counter increments each edge
  - on the edge where the counter reaches HOLD_CYCLES: stage_rst_n[0] goes to 1 and counter clears
  - state then goes to RELEASE, or to RUN with seq_done=1 if NUM_STAGES=1
- RELEASE:
  - counter increments each edge
  - on reaching STAGE_GAP: release the next stage bit and clear the counter
  - the edge that releases bit NUM_STAGES-1 also sets state=RUN and seq_done=1
- Release timing: measured in edges after the first non-reset edge, stage k releases at HOLD_CYCLES + k*STAGE_GAP. With defaults: stage 0 at edge 10, stage 3 and seq_done at edge 58.
- RUN: outputs are static until an accepted request or SYSRESET.
- Release order: released bits stay released; bits are only ever released in ascending index order, and all bits reassert together.
- Latency: ext_rst_req to stage_rst_n=0 is SYNC_STAGES+1 edges. sw_rst_req to stage_rst_n=0 is the edge that samples it.
- SYSRESET priority: SYSRESET mid-sequence overrides everything, including pending requests. It does not increment rst_count.
- Elaboration check: fail elaboration if NUM_STAGES<1, HOLD_CYCLES<1, STAGE_GAP<1, or the counter width is insufficient.

Test Plan:
- Power-up, defaults: SYSRESET high for 5 cycles, then low → stage_rst_n steps 0000→0001 at edge 10, 0011 at 26, 0111 at 42, 1111 at 58; seq_done=1 and state=2 at edge 58; rst_count=0.
- sw_rst_req pulse in RUN → on the sampling edge stage_rst_n=0000, seq_done=0, state=0, rst_count=1; the full sequence repeats with identical 10/16 spacing.
- ext_rst_req held high 20 cycles during RELEASE (stage_rst_n=0011) → all 0000 three edges after the rise; stays in HOLD while high; first release 10 edges after ext_s falls; rst_count increments by exactly 1.
- sw_rst_req and an ext_s rising edge on the same edge, plus 300 further sw pulses → rst_count increments once for the coincident pair and saturates at 255.
- SYSRESET asserted in RELEASE with sw_rst_req also high → stage_rst_n=0, rst_count=0, no increment; the sequence restarts normally after deassertion.
- Variants: NUM_STAGES=1, HOLD_CYCLES=1 → stage_rst_n=1 and seq_done=1 on edge 1, going HOLD→RUN directly. NUM_STAGES=8, STAGE_GAP=1 → consecutive single-edge releases.
